rgb_auto_brightness: RTL and testbench
======================================

Name: rgb_auto_brightness

Overview:
Closed-loop exposure controller that sits directly upstream of the brightness-adjust stage and drives its brightness_level / brightness_enable inputs. It taps the pixel stream (r/g/b + data_valid), computes BT.601-style luma per pixel, and accumulates it over a frame. At frame end it derives the mean luma with a sequential divider. It then steps the brightness level toward a programmable target with hysteresis; the new level applies to the next frame.

Parameters:
CNT_W, 20, pixel-counter width (max 2^CNT_W-1 pixels/frame)
ACC_W, CNT_W+8, luma accumulator width; also the divider iteration count
STEP, 4, brightness_level increment/decrement per frame
DEFAULT_LEVEL, 128, reset value of brightness_level (128 = neutral)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
r_in  in  8  red sample
g_in  in  8  green sample
b_in  in  8  blue sample
data_valid  in  1  pixel qualifier
frame_start  in  1  1-cycle pulse, first cycle of a frame
frame_end  in  1  1-cycle pulse, last cycle of a frame
ctrl_enable  in  1  auto-brightness enable
target_luma  in  8  desired mean luma
hysteresis  in  8  dead band half-width around target
brightness_level  out  8  level to brightness stage
brightness_enable  out  1  enable to brightness stage
mean_luma  out  8  last computed frame mean
mean_valid  out  1  1-cycle pulse when mean_luma/brightness_level update

Behaviour:
- Reset: one clock, one synchronous active-low reset (rst_n sampled on rising clk). Outputs reset to brightness_level=DEFAULT_LEVEL, brightness_enable=0, mean_luma=0, mean_valid=0. acc=0, cnt=0, state=ACCUM. Reset asserted in any state aborts the division immediately.
- Luma: Y = (77*R + 150*G + 29*B) >> 8, combinational, 8-bit result (max 255).
- FSM states: ACCUM, DIVIDE, ADJUST.
- ACCUM:
  - data_valid: acc += Y, cnt += 1. cnt saturates at all-ones; acc stops accumulating once cnt saturates.
  - frame_start: acc/cnt cleared. If data_valid is high in the same cycle, acc=Y, cnt=1.
  - frame_end with resulting cnt != 0 (including a same-cycle pixel, which counts): go to DIVIDE. Otherwise stay; no mean_valid.
  - frame_start and frame_end in the same cycle: treat as a 1-cycle frame (clear, then count that cycle's pixel, then end).
- DIVIDE:
  - Restoring division acc/cnt, one quotient bit per cycle, ACC_W cycles. Quotient truncates (floor); the low 8 bits form the mean, which is always <=255.
  - data_valid, frame_start and frame_end are ignored; those pixels are dropped from statistics.
- ADJUST (1 cycle). Outputs register on the edge leaving ADJUST:
  - mean_luma = quotient; mean_valid = 1 for exactly one cycle.
  - If ctrl_enable=1 and mean + hysteresis < target_luma (9-bit compare): brightness_level += STEP, saturating at 255.
  - If ctrl_enable=1 and mean > target_luma + hysteresis (9-bit compare): brightness_level -= STEP, saturating at 0.
  - Otherwise brightness_level holds. ctrl_enable=0 freezes the level but mean_luma still updates.
  - acc/cnt cleared; next state ACCUM.
- Latency: frame_end sampled at edge E -> mean_valid high in the cycle after edge E+ACC_W+1, i.e. ACC_W+2 cycles.
- brightness_enable = ctrl_enable registered (1-cycle delay) in all states. Deasserting ctrl_enable does not restore DEFAULT_LEVEL.
- mean_valid is 0 in all cycles other than the one described above.

Test Plan:
1. Hold rst_n=0 for 2 cycles mid-DIVIDE -> brightness_level=128, brightness_enable=0, mean_luma=0, mean_valid=0; no mean_valid afterwards without a new frame.
2. ctrl_enable=1, target=100, hyst=4; frame of 16 pixels (100,100,100) -> Y=100, mean_luma=100, mean_valid pulses exactly ACC_W+2 cycles after frame_end; level stays 128.
3. target=128, hyst=8, frames of (0,0,0) -> level 132, 136, ...; 31st frame gives 252, 32nd saturates to 255, 33rd holds 255.
4. target=128, frames of (255,255,255) -> Y=255, level decreases 4 per frame; after 32 frames it is 0, then holds 0.
5. Frame with pixels (255,0,0) and (0,0,255) -> Y=76 and 28, mean_luma=52.
6. Corners:
   - frame_end with no pixels -> no mean_valid.
   - frame_start coincident with a pixel -> that pixel is counted.
   - pixels injected during DIVIDE -> excluded from the next frame mean.
   - ctrl_enable=0 with a dark frame -> mean_valid pulses, level unchanged, brightness_enable=0.

Source files
------------

// File: rtl/rgb_auto_brightness_if.sv
// Pixel-stream tap shared between the video source and the auto-brightness controller.
interface rgb_auto_brightness_if;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       data_valid;
    logic       frame_start;
    logic       frame_end;

    modport master (output r_in, g_in, b_in, data_valid, frame_start, frame_end);
    modport slave  (input  r_in, g_in, b_in, data_valid, frame_start, frame_end);
endinterface

// File: rtl/rgb_auto_brightness.sv
// Closed-loop exposure controller: per-frame mean luma via a restoring divider,
// then a hysteretic step of brightness_level toward target_luma.
module rgb_auto_brightness #(
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned ACC_W         = CNT_W + 8,
    parameter int unsigned STEP          = 4,
    parameter int unsigned DEFAULT_LEVEL = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rgb_auto_brightness_if.slave        pix,
    input  logic                        ctrl_enable,
    input  logic [7:0]                  target_luma,
    input  logic [7:0]                  hysteresis,
    output logic [7:0]                  brightness_level,
    output logic                        brightness_enable,
    output logic [7:0]                  mean_luma,
    output logic                        mean_valid
);

    localparam int unsigned IT_W = $clog2(ACC_W + 1);
    localparam logic [IT_W-1:0] IT_LAST = IT_W'(ACC_W - 1);

    typedef enum logic [1:0] {ACCUM, DIVIDE, ADJUST} state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  rem;
    logic [IT_W-1:0]   iter;

    logic [15:0]       luma_sum;
    logic [7:0]        luma;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W:0]    rem_shift;
    logic [CNT_W:0]    rem_diff;
    logic [7:0]        mean_q;
    logic [8:0]        lo_sum;
    logic [8:0]        hi_sum;
    logic [8:0]        up_level;
    logic              go_up;
    logic              go_down;

    always_comb begin
        luma_sum = 16'd77 * 16'(pix.r_in) + 16'd150 * 16'(pix.g_in) + 16'd29 * 16'(pix.b_in);
        luma     = 8'(luma_sum >> 8);
    end

    // frame_start clears first so a same-cycle pixel (and frame_end) sees a fresh frame
    always_comb begin
        acc_base = pix.frame_start ? '0 : acc;
        cnt_base = pix.frame_start ? '0 : cnt;
        acc_next = acc_base;
        cnt_next = cnt_base;
        if (pix.data_valid && (cnt_base != '1)) begin
            acc_next = acc_base + ACC_W'(luma);
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    // acc doubles as the dividend/quotient shift register; cnt holds the divisor
    always_comb begin
        rem_shift = {rem, acc[ACC_W-1]};
        rem_diff  = rem_shift - {1'b0, cnt};
    end

    always_comb begin
        mean_q   = acc[7:0];
        lo_sum   = {1'b0, mean_q} + {1'b0, hysteresis};
        hi_sum   = {1'b0, target_luma} + {1'b0, hysteresis};
        up_level = {1'b0, brightness_level} + 9'(STEP);
        go_up    = ctrl_enable && (lo_sum < {1'b0, target_luma});
        go_down  = ctrl_enable && ({1'b0, mean_q} > hi_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ACCUM;
            acc               <= '0;
            cnt               <= '0;
            rem               <= '0;
            iter              <= '0;
            brightness_level  <= 8'(DEFAULT_LEVEL);
            brightness_enable <= 1'b0;
            mean_luma         <= '0;
            mean_valid        <= 1'b0;
        end else begin
            brightness_enable <= ctrl_enable;
            mean_valid        <= 1'b0;
            case (state)
                ACCUM: begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    if (pix.frame_end && (cnt_next != '0)) begin
                        state <= DIVIDE;
                        rem   <= '0;
                        iter  <= '0;
                    end
                end
                DIVIDE: begin
                    if (!rem_diff[CNT_W]) begin
                        rem <= rem_diff[CNT_W-1:0];
                        acc <= {acc[ACC_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[CNT_W-1:0];
                        acc <= {acc[ACC_W-2:0], 1'b0};
                    end
                    iter <= iter + IT_W'(1);
                    if (iter == IT_LAST) begin
                        state <= ADJUST;
                    end
                end
                ADJUST: begin
                    mean_luma  <= mean_q;
                    mean_valid <= 1'b1;
                    if (go_up) begin
                        brightness_level <= up_level[8] ? 8'hFF : up_level[7:0];
                    end else if (go_down) begin
                        brightness_level <= (brightness_level < 8'(STEP)) ? 8'h00
                                            : brightness_level - 8'(STEP);
                    end
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_auto_brightness.sv
// Randomised self-checking bench for rgb_auto_brightness against an arithmetic frame model.
module tb_rgb_auto_brightness;

    localparam int CNT_W = 20;
    localparam int ACC_W = 28;
    localparam int STEP  = 4;

    logic       clk;
    logic       rst_n;
    logic       ctrl_enable;
    logic [7:0] target_luma;
    logic [7:0] hysteresis;
    logic [7:0] brightness_level;
    logic       brightness_enable;
    logic [7:0] mean_luma;
    logic       mean_valid;

    rgb_auto_brightness_if pix();

    rgb_auto_brightness #(
        .CNT_W(CNT_W),
        .ACC_W(ACC_W),
        .STEP(STEP),
        .DEFAULT_LEVEL(128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pix(pix),
        .ctrl_enable(ctrl_enable),
        .target_luma(target_luma),
        .hysteresis(hysteresis),
        .brightness_level(brightness_level),
        .brightness_enable(brightness_enable),
        .mean_luma(mean_luma),
        .mean_valid(mean_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_level = 128;

    int q_r[$];
    int q_g[$];
    int q_b[$];

    bit         obs_valid;
    int         obs_lat;
    int         obs_pulses;
    logic [7:0] obs_mean;
    logic [7:0] obs_level;
    logic       obs_ben;

    function automatic int model_y(int r, int g, int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic int model_mean();
        int s = 0;
        foreach (q_r[i]) s += model_y(q_r[i], q_g[i], q_b[i]);
        return s / q_r.size();
    endfunction

    function automatic int model_level(int lvl, int mean, bit en, int tgt, int hy);
        if (!en) return lvl;
        if (mean + hy < tgt) return (lvl + STEP > 255) ? 255 : lvl + STEP;
        if (mean > tgt + hy) return (lvl < STEP) ? 0 : lvl - STEP;
        return lvl;
    endfunction

    task automatic drive_idle();
        pix.data_valid  = 1'b0;
        pix.frame_start = 1'b0;
        pix.frame_end   = 1'b0;
        pix.r_in        = 8'($urandom);
        pix.g_in        = 8'($urandom);
        pix.b_in        = 8'($urandom);
    endtask

    task automatic put(input int i);
        pix.data_valid = 1'b1;
        pix.r_in       = 8'(q_r[i]);
        pix.g_in       = 8'(q_g[i]);
        pix.b_in       = 8'(q_b[i]);
    endtask

    task automatic fill(input int n, input int r, input int g, input int b);
        q_r.delete(); q_g.delete(); q_b.delete();
        for (int i = 0; i < n; i++) begin
            q_r.push_back(r < 0 ? int'($urandom_range(0, 255)) : r);
            q_g.push_back(g < 0 ? int'($urandom_range(0, 255)) : g);
            q_b.push_back(b < 0 ? int'($urandom_range(0, 255)) : b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_level = 128;
    endtask

    // Drives one frame from the queues; the frame_end cycle is left asserted for wait_mean to clear.
    task automatic play_frame(input bit use_fs, input bit fs_pix, input bit fe_pix, input bit gaps);
        int n    = q_r.size();
        int body = (fe_pix && n > 0) ? n - 1 : n;
        int idx  = 0;
        if (use_fs) begin
            @(negedge clk);
            drive_idle();
            pix.frame_start = 1'b1;
            if (fs_pix && idx < body) begin put(idx); idx++; end
        end
        while (idx < body) begin
            @(negedge clk);
            drive_idle();
            if (gaps && $urandom_range(0, 3) == 0) continue;
            put(idx);
            idx++;
        end
        @(negedge clk);
        drive_idle();
        pix.frame_end = 1'b1;
        if (fe_pix && n > 0) put(n - 1);
    endtask

    task automatic wait_mean(input bit inject);
        obs_valid  = 0;
        obs_lat    = 0;
        obs_pulses = 0;
        for (int k = 1; k <= ACC_W + 8; k++) begin
            @(negedge clk);
            if (mean_valid === 1'b1) begin
                obs_pulses++;
                if (!obs_valid) begin
                    obs_valid = 1;
                    obs_lat   = k;
                    obs_mean  = mean_luma;
                    obs_level = brightness_level;
                    obs_ben   = brightness_enable;
                end
            end
            drive_idle();
            if (inject && k < ACC_W) begin
                pix.data_valid  = 1'b1;
                pix.frame_start = (k == 3);
                pix.frame_end   = (k == 7);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ctrl_enable = 1'b1;
        target_luma = 8'd200;
        hysteresis  = 8'd4;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        checks++; if (brightness_level !== 8'd128) begin errors++; $display("FAIL por_level got %0d exp 128", brightness_level); end
        checks++; if (brightness_enable !== 1'b0) begin errors++; $display("FAIL por_enable got %b exp 0", brightness_enable); end
        checks++; if (mean_luma !== 8'd0) begin errors++; $display("FAIL por_mean got %0d exp 0", mean_luma); end
        checks++; if (mean_valid !== 1'b0) begin errors++; $display("FAIL por_valid got %b exp 0", mean_valid); end
        rst_n = 1'b1;
        exp_level = 128;
        // one gray frame so the outputs leave their reset values
        fill(8, 100, 100, 100);
        play_frame(1, 0, 0, 0);
        wait_mean(0);
        exp_level = model_level(exp_level, 100, 1, 200, 4);
        checks++; if (obs_level !== 8'(exp_level) || obs_mean !== 8'd100) begin errors++; $display("FAIL pre_reset_frame got lvl %0d mean %0d exp lvl %0d mean 100", obs_level, obs_mean, exp_level); end
        fill(6, -1, -1, -1);
        play_frame(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin @(negedge clk); drive_idle(); end
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (brightness_level !== 8'd128) begin errors++; $display("FAIL rst_div_level got %0d exp 128", brightness_level); end
        checks++; if (brightness_enable !== 1'b0) begin errors++; $display("FAIL rst_div_enable got %b exp 0", brightness_enable); end
        checks++; if (mean_luma !== 8'd0) begin errors++; $display("FAIL rst_div_mean got %0d exp 0", mean_luma); end
        checks++; if (mean_valid !== 1'b0) begin errors++; $display("FAIL rst_div_valid got %b exp 0", mean_valid); end
        rst_n = 1'b1;
        exp_level = 128;
        wait_mean(0);
        checks++; if (obs_pulses != 0) begin errors++; $display("FAIL rst_div_no_pulse got %0d pulses exp 0", obs_pulses); end
    endtask

    task automatic test_neutral();
        ctrl_enable = 1'b1;
        target_luma = 8'd100;
        hysteresis  = 8'd4;
        fill(16, 100, 100, 100);
        play_frame(1, 0, 0, 0);
        wait_mean(0);
        checks++; if (!obs_valid) begin errors++; $display("FAIL neutral_valid got none exp pulse"); end
        checks++; if (obs_lat != ACC_W + 2) begin errors++; $display("FAIL neutral_latency got %0d exp %0d", obs_lat, ACC_W + 2); end
        checks++; if (obs_pulses != 1) begin errors++; $display("FAIL neutral_width got %0d exp 1", obs_pulses); end
        checks++; if (obs_mean !== 8'd100) begin errors++; $display("FAIL neutral_mean got %0d exp 100", obs_mean); end
        checks++; if (obs_level !== 8'd128) begin errors++; $display("FAIL neutral_level got %0d exp 128", obs_level); end
        checks++; if (obs_ben !== 1'b1) begin errors++; $display("FAIL neutral_enable got %b exp 1", obs_ben); end
    endtask

    task automatic test_ramp_up();
        ctrl_enable = 1'b1;
        target_luma = 8'd128;
        hysteresis  = 8'd8;
        for (int f = 1; f <= 33; f++) begin
            fill(8, 0, 0, 0);
            play_frame(1, 0, 0, 0);
            wait_mean(0);
            exp_level = model_level(exp_level, 0, 1, 128, 8);
            checks++; if (!obs_valid || obs_mean !== 8'd0 || obs_level !== 8'(exp_level)) begin errors++; $display("FAIL ramp_up frame %0d got valid %0d mean %0d lvl %0d exp mean 0 lvl %0d", f, obs_valid, obs_mean, obs_level, exp_level); end
            if (f == 31) begin checks++; if (obs_level !== 8'd252) begin errors++; $display("FAIL ramp_up_31 got %0d exp 252", obs_level); end end
            if (f == 32) begin checks++; if (obs_level !== 8'd255) begin errors++; $display("FAIL ramp_up_sat got %0d exp 255", obs_level); end end
            if (f == 33) begin checks++; if (obs_level !== 8'd255) begin errors++; $display("FAIL ramp_up_hold got %0d exp 255", obs_level); end end
        end
    endtask

    task automatic test_ramp_down();
        do_reset();
        ctrl_enable = 1'b1;
        target_luma = 8'd128;
        hysteresis  = 8'd8;
        for (int f = 1; f <= 33; f++) begin
            fill(8, 255, 255, 255);
            play_frame(1, 0, 0, 1);
            wait_mean(0);
            exp_level = model_level(exp_level, 255, 1, 128, 8);
            checks++; if (!obs_valid || obs_mean !== 8'd255 || obs_level !== 8'(exp_level)) begin errors++; $display("FAIL ramp_down frame %0d got valid %0d mean %0d lvl %0d exp mean 255 lvl %0d", f, obs_valid, obs_mean, obs_level, exp_level); end
            if (f == 32) begin checks++; if (obs_level !== 8'd0) begin errors++; $display("FAIL ramp_down_zero got %0d exp 0", obs_level); end end
            if (f == 33) begin checks++; if (obs_level !== 8'd0) begin errors++; $display("FAIL ramp_down_hold got %0d exp 0", obs_level); end end
        end
    endtask

    task automatic test_mixed();
        ctrl_enable = 1'b1;
        target_luma = 8'd52;
        hysteresis  = 8'd0;
        q_r = '{255, 0};
        q_g = '{0, 0};
        q_b = '{0, 255};
        play_frame(1, 0, 0, 0);
        wait_mean(0);
        checks++; if (obs_mean !== 8'd52 || obs_mean !== 8'(model_mean())) begin errors++; $display("FAIL mixed_mean got %0d exp 52", obs_mean); end
        checks++; if (obs_level !== 8'(exp_level)) begin errors++; $display("FAIL mixed_level got %0d exp %0d", obs_level, exp_level); end
    endtask

    task automatic test_corners();
        int em;
        int y;
        ctrl_enable = 1'b1;
        target_luma = 8'($urandom_range(0, 255));
        hysteresis  = 8'($urandom_range(0, 20));
        // empty frame
        fill(0, 0, 0, 0);
        play_frame(1, 0, 0, 0);
        wait_mean(0);
        checks++; if (obs_pulses != 0) begin errors++; $display("FAIL empty_frame got %0d pulses exp 0", obs_pulses); end
        // frame_start and frame_end both carrying a pixel
        fill(3, -1, -1, -1);
        em = model_mean();
        play_frame(1, 1, 1, 0);
        wait_mean(0);
        exp_level = model_level(exp_level, em, 1, target_luma, hysteresis);
        checks++; if (!obs_valid || obs_mean !== 8'(em) || obs_level !== 8'(exp_level)) begin errors++; $display("FAIL fs_pixel got valid %0d mean %0d lvl %0d exp mean %0d lvl %0d", obs_valid, obs_mean, obs_level, em, exp_level); end
        // stray pixels, then a one-cycle frame that must discard them
        for (int k = 0; k < 3; k++) begin @(negedge clk); drive_idle(); pix.data_valid = 1'b1; end
        @(negedge clk);
        drive_idle();
        pix.r_in = 8'($urandom); pix.g_in = 8'($urandom); pix.b_in = 8'($urandom);
        y = model_y(pix.r_in, pix.g_in, pix.b_in);
        pix.frame_start = 1'b1; pix.frame_end = 1'b1; pix.data_valid = 1'b1;
        wait_mean(0);
        exp_level = model_level(exp_level, y, 1, target_luma, hysteresis);
        checks++; if (!obs_valid || obs_mean !== 8'(y) || obs_level !== 8'(exp_level)) begin errors++; $display("FAIL one_cycle_frame got valid %0d mean %0d lvl %0d exp mean %0d lvl %0d", obs_valid, obs_mean, obs_level, y, exp_level); end
        // activity during DIVIDE, then a frame with no frame_start
        fill(5, -1, -1, -1);
        em = model_mean();
        play_frame(1, 0, 0, 0);
        wait_mean(1);
        exp_level = model_level(exp_level, em, 1, target_luma, hysteresis);
        checks++; if (!obs_valid || obs_pulses != 1 || obs_mean !== 8'(em) || obs_level !== 8'(exp_level)) begin errors++; $display("FAIL inject_div got pulses %0d mean %0d lvl %0d exp 1 mean %0d lvl %0d", obs_pulses, obs_mean, obs_level, em, exp_level); end
        fill(4, -1, -1, -1);
        em = model_mean();
        play_frame(0, 0, 0, 0);
        wait_mean(0);
        exp_level = model_level(exp_level, em, 1, target_luma, hysteresis);
        checks++; if (!obs_valid || obs_mean !== 8'(em) || obs_level !== 8'(exp_level)) begin errors++; $display("FAIL after_inject got valid %0d mean %0d lvl %0d exp mean %0d lvl %0d", obs_valid, obs_mean, obs_level, em, exp_level); end
        // disabled control with a dark frame
        ctrl_enable = 1'b0;
        target_luma = 8'd128;
        hysteresis  = 8'd8;
        fill(8, 0, 0, 0);
        play_frame(1, 0, 0, 0);
        wait_mean(0);
        checks++; if (!obs_valid || obs_mean !== 8'd0) begin errors++; $display("FAIL disabled_mean got valid %0d mean %0d exp 1 0", obs_valid, obs_mean); end
        checks++; if (obs_level !== 8'(exp_level)) begin errors++; $display("FAIL disabled_level got %0d exp %0d", obs_level, exp_level); end
        checks++; if (obs_ben !== 1'b0) begin errors++; $display("FAIL disabled_enable got %b exp 0", obs_ben); end
    endtask

    task automatic test_random();
        int em;
        bit en;
        for (int f = 0; f < 25; f++) begin
            en = 1'($urandom_range(0, 3) != 0);
            ctrl_enable = en;
            target_luma = 8'($urandom);
            hysteresis  = 8'($urandom_range(0, 40));
            fill(int'($urandom_range(1, 30)), -1, -1, -1);
            em = model_mean();
            play_frame(1, 1'($urandom), 1'($urandom), 1);
            wait_mean(1'($urandom));
            exp_level = model_level(exp_level, em, en, target_luma, hysteresis);
            checks++; if (!obs_valid || obs_lat != ACC_W + 2 || obs_pulses != 1) begin errors++; $display("FAIL rand_timing frame %0d got valid %0d lat %0d pulses %0d exp 1 %0d 1", f, obs_valid, obs_lat, obs_pulses, ACC_W + 2); end
            checks++; if (obs_mean !== 8'(em) || obs_level !== 8'(exp_level) || obs_ben !== en) begin errors++; $display("FAIL rand_result frame %0d got mean %0d lvl %0d en %b exp %0d %0d %b", f, obs_mean, obs_level, obs_ben, em, exp_level, en); end
        end
    endtask

    initial begin
        test_reset();
        test_neutral();
        test_ramp_up();
        test_ramp_down();
        test_mixed();
        test_corners();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
